piso_bit_serializer: RTL

Parallel-in/serial-out stage that sits directly upstream of the serial "1101" sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first, one bit per clock, onto the detector's single-bit `din` input. It also provides a qualifying valid, a busy flag and a sent-word counter.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_skid_buf.sv | 36 +++
 rtl/piso_bit_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and default parameters for the PISO bit serializer.
// Pure declarations: no latency and no flow control live here.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_state_t;

  localparam int PISO_WIDTH_DEF = 8;
  localparam int PISO_GAP_DEF   = 0;
  localparam int PISO_CNT_W_DEF = 16;

endpackage

// File: rtl/piso_skid_buf.sv
// One-entry valid/ready slice that bypasses when empty; zero latency on bypass, one word held otherwise.
// Backpressure: s_rdy drops only while the entry is occupied and is independent of m_rdy.
module piso_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_vld,
  input  logic [WIDTH-1:0] s_dat,
  output logic             s_rdy,
  output logic             m_vld,
  output logic [WIDTH-1:0] m_dat,
  input  logic             m_rdy
);

  logic             full_q;
  logic [WIDTH-1:0] buf_q;

  assign s_rdy = !full_q;
  assign m_vld = full_q | s_vld;
  assign m_dat = full_q ? buf_q : s_dat;

  // A held word always drains before a new one is accepted, so ordering is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (full_q) begin
      if (m_rdy) full_q <= 1'b0;
    end else if (s_vld && !m_rdy) begin
      full_q <= 1'b1;
      buf_q  <= s_dat;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// MSB-first word serializer: bit i of a word accepted at edge k is on dout in cycle k+1+i.
// Backpressure via in_ready (state-derived, or !buf_full when PISO_SKID_BUF_EN is defined).
module piso_bit_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = PISO_WIDTH_DEF,
  parameter int GAP_CYCLES = PISO_GAP_DEF,
  parameter int CNT_W      = PISO_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  piso_state_t      state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_vld_q, busy_q;
  logic [CNT_W-1:0] words_sent_q;
  logic             last_bit, last_gap, shift_rdy, load, word_done;
  logic             ld_vld;
  logic [WIDTH-1:0] ld_dat;

  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign last_gap  = (state_q == GAP) && (gap_cnt_q == LAST_GAP);
  assign shift_rdy = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)) || last_gap;

`ifdef PISO_SKID_BUF_EN
  logic skid_s_rdy;

  piso_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (in_valid),
    .s_dat (in_data),
    .s_rdy (skid_s_rdy),
    .m_vld (ld_vld),
    .m_dat (ld_dat),
    .m_rdy (shift_rdy)
  );

  assign in_ready = skid_s_rdy & rst_n;
`else
  assign ld_vld   = in_valid;
  assign ld_dat   = in_data;
  assign in_ready = shift_rdy & rst_n;
`endif

  assign load = ld_vld & shift_rdy;

  // The register is loaded with the whole word so dout is simply its MSB flop;
  // zeros shifted in keep dout low once the word has drained.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = SHIFT;
          shreg_d   = ld_dat;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          word_done = 1'b1;
          bit_cnt_d = '0;
          if (load) begin
            shreg_d = ld_dat;
          end else if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (last_gap) begin
          gap_cnt_d = '0;
          if (load) begin
            state_d   = SHIFT;
            shreg_d   = ld_dat;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shreg_q      <= '0;
      dout_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shreg_q    <= shreg_d;
      dout_vld_q <= (state_d == SHIFT);
      busy_q     <= (state_d != IDLE);
      if (word_done) words_sent_q <= words_sent_q + 1'b1;
    end
  end

  assign dout       = shreg_q[WIDTH-1];
  assign dout_valid = dout_vld_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule
